psa_simd_pipe: RTL

- Parametrised, pipelined successor to the 16-bit parallel sub-word adder: LANES independent signed lanes of LANE_W bits each.
- Each lane computes add or subtract, with optional saturation, per-lane overflow flags and a sticky overflow status register.
- Valid/ready handshakes on input and output; 2-stage pipeline with full backpressure.
- Feeds the execute-stage SIMD path.

---
 rtl/psa_pkg.sv | 24 ++
 rtl/psa_simd_pipe_if.sv | 41 ++++
 rtl/psa_lane.sv | 29 ++
 rtl/psa_simd_pipe.sv | 128 ++++++++++++
 4 files changed

// File: rtl/psa_pkg.sv
// rtl/psa_pkg.sv - op encodings, saturation helpers and the S1 lane record shared by psa_simd_pipe
package psa_pkg;

    localparam logic PSA_ADD = 1'b0;
    localparam logic PSA_SUB = 1'b1;

    // Widest lane the S1 record can carry; a lane of LANE_W bits uses raw[LANE_W-1:0], LANE_W < 64.
    localparam int PSA_RAW_W = 64;

    typedef struct packed {
        logic [PSA_RAW_W-1:0] raw;
        logic                 pos_ovfl;
        logic                 neg_ovfl;
    } psa_s1_lane_t;

    function automatic logic [PSA_RAW_W-1:0] lane_max(input int lane_w);
        return (PSA_RAW_W'(1) << (lane_w - 1)) - PSA_RAW_W'(1);
    endfunction

    function automatic logic [PSA_RAW_W-1:0] lane_min(input int lane_w);
        return PSA_RAW_W'(1) << (lane_w - 1);
    endfunction

endpackage

// File: rtl/psa_simd_pipe_if.sv
// rtl/psa_simd_pipe_if.sv - operand/result handshake bundle for psa_simd_pipe; ovfl_cnt exists only under PSA_OVFL_CNT_EN
interface psa_simd_pipe_if #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
);
    localparam int W = LANE_W * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             op;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     Sum;
    logic [LANES-1:0] lane_ovfl;
    logic             Error;
    logic [LANES-1:0] sticky_ovfl;
    logic             clr_sticky;
`ifdef PSA_OVFL_CNT_EN
    logic [15:0]      ovfl_cnt;
`endif

    modport master (
        output in_valid, A, B, op, sat_en, out_ready, clr_sticky,
        input  in_ready, out_valid, Sum, lane_ovfl, Error, sticky_ovfl
`ifdef PSA_OVFL_CNT_EN
        , input ovfl_cnt
`endif
    );

    modport slave (
        input  in_valid, A, B, op, sat_en, out_ready, clr_sticky,
        output in_ready, out_valid, Sum, lane_ovfl, Error, sticky_ovfl
`ifdef PSA_OVFL_CNT_EN
        , output ovfl_cnt
`endif
    );

endinterface

// File: rtl/psa_lane.sv
// rtl/psa_lane.sv - combinational single-lane signed add/sub with overflow detect
module psa_lane
    import psa_pkg::*;
#(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              op,
    output psa_s1_lane_t      res
);

    logic              sub;
    logic [LANE_W-1:0] b_eff;
    logic [LANE_W-1:0] sum;

    // Subtract as A + ~B + 1 so overflow uses the signs the adder actually saw;
    // this makes 0 - most_negative show up as positive overflow.
    always_comb begin
        sub          = (op == PSA_SUB);
        b_eff        = sub ? ~b : b;
        sum          = a + b_eff + LANE_W'(sub);
        res          = '0;
        res.raw      = PSA_RAW_W'(sum);
        res.pos_ovfl = ~a[LANE_W-1] & ~b_eff[LANE_W-1] &  sum[LANE_W-1];
        res.neg_ovfl =  a[LANE_W-1] &  b_eff[LANE_W-1] & ~sum[LANE_W-1];
    end

endmodule

// File: rtl/psa_simd_pipe.sv
// rtl/psa_simd_pipe.sv - 2-stage LANES x LANE_W signed SIMD add/sub with saturation and sticky overflow; PSA_OVFL_CNT_EN adds ovfl_cnt
module psa_simd_pipe
    import psa_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic           clk,
    input  logic           rst,
    psa_simd_pipe_if.slave bus
);

    localparam int W = LANE_W * LANES;
    localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(lane_max(LANE_W));
    localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(lane_min(LANE_W));

    psa_s1_lane_t [LANES-1:0] lane_res;
    psa_s1_lane_t [LANES-1:0] s1_lane_q, s1_lane_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_sat_q, s1_sat_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [W-1:0]             sum_q, sum_d;
    logic [LANES-1:0]         lane_ovfl_q, lane_ovfl_d;
    logic [LANES-1:0]         sticky_q, sticky_d;
    logic [LANE_W-1:0]        lane_val;
    logic                     s1_adv, in_ready, in_fire, out_fire;
    logic [LANES-1:0]         unused_raw_hi;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psa_lane #(.LANE_W(LANE_W)) u_lane (
            .a   (bus.A[g*LANE_W +: LANE_W]),
            .b   (bus.B[g*LANE_W +: LANE_W]),
            .op  (bus.op),
            .res (lane_res[g])
        );
        assign unused_raw_hi[g] = ^s1_lane_q[g].raw[PSA_RAW_W-1:LANE_W];
    end

    always_comb begin
        s1_adv   = !s2_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s1_adv;
        in_fire  = bus.in_valid && in_ready;
        out_fire = s2_valid_q && bus.out_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lane_d  = s1_lane_q;
        s1_sat_d   = s1_sat_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_lane_d  = lane_res;
            s1_sat_d   = bus.sat_en;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Output data only reloads on a real beat, so Sum stays put while stalled or idle.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        sum_d       = sum_q;
        lane_ovfl_d = lane_ovfl_q;
        lane_val    = '0;
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    lane_val = s1_lane_q[i].raw[LANE_W-1:0];
                    if (s1_sat_q && s1_lane_q[i].pos_ovfl) lane_val = SAT_MAX;
                    if (s1_sat_q && s1_lane_q[i].neg_ovfl) lane_val = SAT_MIN;
                    sum_d[i*LANE_W +: LANE_W] = lane_val;
                    lane_ovfl_d[i] = s1_lane_q[i].pos_ovfl | s1_lane_q[i].neg_ovfl;
                end
            end
        end
    end

    // Clear first, then OR in the transferring beat: a coincident overflow survives the clear.
    always_comb begin
        sticky_d = bus.clr_sticky ? '0 : sticky_q;
        if (out_fire) sticky_d = sticky_d | lane_ovfl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_lane_q   <= '0;
            s1_sat_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            sum_q       <= '0;
            lane_ovfl_q <= '0;
            sticky_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lane_q   <= s1_lane_d;
            s1_sat_q    <= s1_sat_d;
            s2_valid_q  <= s2_valid_d;
            sum_q       <= sum_d;
            lane_ovfl_q <= lane_ovfl_d;
            sticky_q    <= sticky_d;
        end
    end

`ifdef PSA_OVFL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = bus.clr_sticky ? 16'h0000 : cnt_q;
        if (out_fire && (|lane_ovfl_q) && (cnt_d != 16'hFFFF)) cnt_d = cnt_d + 16'h0001;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.ovfl_cnt = cnt_q;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_valid_q;
    assign bus.Sum         = sum_q;
    assign bus.lane_ovfl   = lane_ovfl_q;
    assign bus.Error       = |lane_ovfl_q;
    assign bus.sticky_ovfl = sticky_q;

endmodule
